sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Parametrised multi-port bridge between N strobe/ack bus masters and one req/ack SDRAM controller.
- Typical masters: CPU, DMA or disk engine, video fetch.
- Replaces the single-port stb/ack reply logic and byte-mask register in the board top.
- Adds round-robin arbitration, per-port latching, read-data capture, a request watchdog, and generic data/byte widths.

Parameters:
- NPORT, 2: number of master ports (1..8).
- AW, 21: word-address width (byte address bits [AW:1]).
- DW, 16: data width; must be a multiple of 8.
- SW, DW/8: byte-select width (derived).
- TMO, 1023: watchdog limit in clk cycles for one controller request; 0 disables the watchdog.

Ports:
- clk  in  1  controller clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- p_stb  in  NPORT  per-port transaction strobe, held until ack.
- p_we  in  NPORT  per-port write enable.
- p_sel  in  NPORT*SW  per-port byte selects, active high; port i occupies slice [i*SW +: SW].
- p_adr  in  NPORT*AW  per-port word addresses.
- p_wdat  in  NPORT*DW  per-port write data.
- p_rdat  out  DW  read data, shared by all ports; valid while that port's p_ack is high.
- p_ack  out  NPORT  per-port acknowledge.
- c_ready  in  1  controller init-done.
- c_wr_req  out  1  write request.
- c_rd_req  out  1  read request.
- c_wr_ack  in  1  controller write acknowledge, one-cycle pulse.
- c_rd_ack  in  1  controller read acknowledge, one-cycle pulse; c_rdat is valid in that cycle.
- c_adr  out  AW  latched address.
- c_wdat  out  DW  latched write data.
- c_rdat  in  DW  controller read data.
- c_dm  out  SW  data mask, active high = byte masked.
- grant  out  $clog2(NPORT)  index of the port currently served.
- busy  out  1  high whenever the FSM is not in IDLE.
- tmo_err  out  1  sticky watchdog flag.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All outputs are 0, except c_dm = all ones.
  - FSM goes to IDLE; round-robin pointer = 0; watchdog counter = 0.
  - A reset during an active transaction abandons it; no ack is issued.
- IDLE:
  - Waits for c_ready=1 and any p_stb set.
  - Winner = first port with p_stb set, scanning from pointer upward, modulo NPORT.
  - On the edge: latch grant, we, adr, wdat.
  - c_dm is latched as ~sel for writes and 0 for reads; reads are always full-word.
  - Go to REQ.
- REQ:
  - c_wr_req = we, c_rd_req = ~we; both are driven from registers.
  - Stay until the matching ack; an ack of the wrong type is ignored.
  - On c_rd_ack: p_rdat <= c_rdat.
  - On the matching ack: go to ACK.
  - Watchdog counts cycles spent in REQ. When it reaches TMO (TMO≠0): set tmo_err, drop the request, go to ACK (p_rdat unchanged).
- ACK:
  - p_ack[grant] = 1 while p_stb[grant] = 1.
  - When p_stb[grant] is sampled 0: p_ack <= 0, pointer <= grant+1 (mod NPORT), go to IDLE.
  - If the strobe already dropped during REQ, ACK lasts one cycle with p_ack low.
- Latency:
  - Strobe sampled at edge 0 → c_*_req high from edge 1.
  - Ack pulse at edge k → p_ack high from edge k+1.
  - Minimum one idle cycle between grants.
- Port inputs are sampled only in IDLE. Changes to a granted port's inputs during REQ or ACK are ignored.
- At most one p_ack bit is high at any time. c_wr_req and c_rd_req are never both high.
- While c_ready=0 no grant is made; strobes stay pending without ack.
- tmo_err clears only on reset.
- NPORT=1: grant is 1 bit wide and tied to 0.

Decomposition:
- Package sdram_arb_pkg holds:
  - state encoding (IDLE, REQ, ACK);
  - function clog2_min1 (returns ≥1);
  - the TMO counter width constant.
- Sub-module rr_arbiter(NPORT) holds the purely combinational winner search from req vector and pointer to grant index plus valid. It is instantiated once.
- Port-slice extraction stays in the top.

Test Plan:
1. Single write: port0 stb, we=1, sel=2'b01, adr=21'h00123, wdat=16'hA55A, controller acks after 3 cycles → c_wr_req high 3 cycles, c_dm=2'b10, c_adr=21'h00123, p_ack[0] high one cycle after ack until stb drops.
2. Read: port1 reads adr=21'h1FFFF with c_rdat=16'hBEEF on c_rd_ack → c_dm=0, p_rdat=16'hBEEF with p_ack[1], grant=1.
3. Contention: both ports strobe simultaneously and continuously, pointer=0 → grants 0,1,0,1; the alternation holds across 4 transactions.
4. Not ready: c_ready=0 for 20 cycles with port0 strobing → no c_*_req, busy=0; requests start the cycle after c_ready rises.
5. Watchdog: TMO=8, controller never acks → tmo_err=1 after 8 REQ cycles, request dropped, p_ack[0] high, FSM returns to IDLE when stb drops.
6. Reset mid-REQ: rst_n=0 for one edge → c_wr_req=0, p_ack=0, c_dm=all ones, busy=0, tmo_err=0; the next strobe is served normally.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the multi-port SDRAM arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } arb_state_t;

    // Watchdog counter width; TMO must fit below 2**TMO_CW.
    localparam int TMO_CW = 16;

    // Index width that never collapses to zero bits for a single port.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner search: first set request at or above ptr, wrapping.
module rr_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NPORT = 2,
    parameter int GW    = clog2_min1(NPORT)
) (
    input  logic [NPORT-1:0] req,
    input  logic [GW-1:0]    ptr,
    output logic [GW-1:0]    idx,
    output logic             valid
);

    int j;

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int k = 0; k < NPORT; k++) begin
            j = (int'(ptr) + k) % NPORT;
            if (!valid && req[j]) begin
                valid = 1'b1;
                idx   = GW'(j);
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Multi-port strobe/ack bridge onto a single req/ack SDRAM controller with
// round-robin arbitration, request latching, read-data capture and a watchdog.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NPORT = 2,
    parameter int AW    = 21,
    parameter int DW    = 16,
    parameter int SW    = DW / 8,
    parameter int TMO   = 1023
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NPORT-1:0]             p_stb,
    input  logic [NPORT-1:0]             p_we,
    input  logic [NPORT*SW-1:0]          p_sel,
    input  logic [NPORT*AW-1:0]          p_adr,
    input  logic [NPORT*DW-1:0]          p_wdat,
    output logic [DW-1:0]                p_rdat,
    output logic [NPORT-1:0]             p_ack,
    input  logic                         c_ready,
    output logic                         c_wr_req,
    output logic                         c_rd_req,
    input  logic                         c_wr_ack,
    input  logic                         c_rd_ack,
    output logic [AW-1:0]                c_adr,
    output logic [DW-1:0]                c_wdat,
    input  logic [DW-1:0]                c_rdat,
    output logic [SW-1:0]                c_dm,
    output logic [clog2_min1(NPORT)-1:0] grant,
    output logic                         busy,
    output logic                         tmo_err
);

    localparam int GW = clog2_min1(NPORT);
    localparam logic [TMO_CW-1:0] TMO_LIM = TMO_CW'((TMO == 0) ? 0 : TMO - 1);

    arb_state_t        state, state_nx;
    logic [GW-1:0]     ptr, ptr_nx;
    logic [GW-1:0]     win_idx;
    logic              win_vld;
    logic              win_we;
    logic [SW-1:0]     win_sel;
    logic [AW-1:0]     win_adr;
    logic [DW-1:0]     win_wdat;
    logic              we_q;
    logic              stb_g;
    logic [NPORT-1:0]  ack_vec;
    logic [TMO_CW-1:0] wd_cnt;
    logic              take, done, tmo_hit, rel;

    rr_arbiter #(.NPORT(NPORT), .GW(GW)) u_rr (
        .req   (p_stb),
        .ptr   (ptr),
        .idx   (win_idx),
        .valid (win_vld)
    );

    assign win_we   = p_we[win_idx];
    assign win_sel  = p_sel[int'(win_idx)*SW +: SW];
    assign win_adr  = p_adr[int'(win_idx)*AW +: AW];
    assign win_wdat = p_wdat[int'(win_idx)*DW +: DW];

    assign stb_g  = p_stb[grant];
    assign busy   = (state != ST_IDLE);
    assign ptr_nx = (grant == GW'(NPORT - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        ack_vec        = '0;
        ack_vec[grant] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        take     = 1'b0;
        done     = 1'b0;
        tmo_hit  = 1'b0;
        rel      = 1'b0;
        case (state)
            ST_IDLE: if (c_ready && win_vld) begin
                state_nx = ST_REQ;
                take     = 1'b1;
            end
            ST_REQ: begin
                // A matching ack beats a same-cycle timeout.
                if ((we_q && c_wr_ack) || (!we_q && c_rd_ack)) begin
                    state_nx = ST_ACK;
                    done     = 1'b1;
                end else if (TMO != 0 && wd_cnt == TMO_LIM) begin
                    state_nx = ST_ACK;
                    tmo_hit  = 1'b1;
                end
            end
            ST_ACK: if (!stb_g) begin
                state_nx = ST_IDLE;
                rel      = 1'b1;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant    <= '0;
            ptr      <= '0;
            we_q     <= 1'b0;
            c_adr    <= '0;
            c_wdat   <= '0;
            c_dm     <= '1;
            c_wr_req <= 1'b0;
            c_rd_req <= 1'b0;
            p_ack    <= '0;
            p_rdat   <= '0;
            tmo_err  <= 1'b0;
            wd_cnt   <= '0;
        end else begin
            wd_cnt <= (state == ST_REQ) ? wd_cnt + 1'b1 : '0;
            if (take) begin
                grant    <= win_idx;
                we_q     <= win_we;
                c_adr    <= win_adr;
                c_wdat   <= win_wdat;
                c_dm     <= win_we ? ~win_sel : '0;
                c_wr_req <= win_we;
                c_rd_req <= !win_we;
            end
            if (state == ST_REQ && !we_q && c_rd_ack)
                p_rdat <= c_rdat;
            if (done || tmo_hit) begin
                c_wr_req <= 1'b0;
                c_rd_req <= 1'b0;
                p_ack    <= stb_g ? ack_vec : '0;
            end
            if (tmo_hit)
                tmo_err <= 1'b1;
            if (rel) begin
                p_ack <= '0;
                ptr   <= ptr_nx;
            end
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed-vector bench for sdram_port_arbiter (NPORT=2, TMO=8).
module tb_sdram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  p_stb, p_we;
    logic [3:0]  p_sel;
    logic [41:0] p_adr;
    logic [31:0] p_wdat;
    logic [15:0] p_rdat;
    logic [1:0]  p_ack;
    logic        c_ready, c_wr_req, c_rd_req, c_wr_ack, c_rd_ack;
    logic [20:0] c_adr;
    logic [15:0] c_wdat, c_rdat;
    logic [1:0]  c_dm;
    logic [0:0]  grant;
    logic        busy, tmo_err;

    int n_chk = 0;
    int n_err = 0;

    sdram_port_arbiter #(.NPORT(2), .AW(21), .DW(16), .TMO(8)) dut (
        .clk(clk), .rst_n(rst_n), .p_stb(p_stb), .p_we(p_we), .p_sel(p_sel),
        .p_adr(p_adr), .p_wdat(p_wdat), .p_rdat(p_rdat), .p_ack(p_ack),
        .c_ready(c_ready), .c_wr_req(c_wr_req), .c_rd_req(c_rd_req),
        .c_wr_ack(c_wr_ack), .c_rd_ack(c_rd_ack), .c_adr(c_adr), .c_wdat(c_wdat),
        .c_rdat(c_rdat), .c_dm(c_dm), .grant(grant), .busy(busy), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for a request, check its grant, ack it, then release the strobe.
    task automatic serve(input int g);
        int n;
        n = 0;
        tick();
        while (!(c_wr_req || c_rd_req) && n < 50) begin
            tick();
            n++;
        end
        chk("serve_req_seen", 32'(c_wr_req || c_rd_req), 1);
        chk("serve_grant", 32'(grant), 32'(g));
        c_wr_ack = c_wr_req;
        c_rd_ack = c_rd_req;
        tick();
        c_wr_ack = 1'b0;
        c_rd_ack = 1'b0;
        chk("serve_ack", 32'(p_ack), 32'(1 << g));
        p_stb[g] = 1'b0;
        tick();
        chk("serve_release", 32'({p_ack, busy}), 0);
    endtask

    initial begin
        int n;
        logic flag;
        rst_n = 1'b0; p_stb = '0; p_we = '0; p_sel = '0; p_adr = '0; p_wdat = '0;
        c_ready = 1'b1; c_wr_ack = 1'b0; c_rd_ack = 1'b0; c_rdat = '0;
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_dm", 32'(c_dm), 32'h3);
        chk("rst_outs", 32'({c_wr_req, c_rd_req, p_ack, busy, tmo_err, grant}), 0);
        chk("rst_rdat", 32'(p_rdat), 0);

        // 1: single write on port 0, ack after 3 request cycles
        p_stb = 2'b01; p_we = 2'b01; p_sel = 4'b0001;
        p_adr[20:0] = 21'h00123; p_wdat[15:0] = 16'hA55A;
        tick();
        chk("w_req", 32'({c_wr_req, c_rd_req}), 32'h2);
        chk("w_dm", 32'(c_dm), 32'h2);
        chk("w_adr", 32'(c_adr), 32'h00123);
        chk("w_wdat", 32'(c_wdat), 32'hA55A);
        n = 1;
        tick(); n += int'(c_wr_req);
        tick(); n += int'(c_wr_req);
        c_wr_ack = 1'b1;
        tick();
        c_wr_ack = 1'b0;
        chk("w_req_cycles", 32'(n), 3);
        chk("w_req_drop", 32'(c_wr_req), 0);
        chk("w_ack", 32'(p_ack), 32'h1);
        tick();
        chk("w_ack_hold", 32'(p_ack), 32'h1);
        p_stb = 2'b00;
        tick();
        chk("w_done", 32'({p_ack, busy}), 0);

        // 2: read on port 1 (pointer now 1)
        p_stb = 2'b10; p_we = 2'b00; p_adr[41:21] = 21'h1FFFF;
        tick();
        chk("r_req", 32'({c_wr_req, c_rd_req}), 32'h1);
        chk("r_dm", 32'(c_dm), 0);
        chk("r_grant", 32'(grant), 1);
        chk("r_adr", 32'(c_adr), 32'h1FFFF);
        c_rd_ack = 1'b1; c_rdat = 16'hBEEF;
        tick();
        c_rd_ack = 1'b0; c_rdat = 16'h0000;
        chk("r_ack", 32'(p_ack), 32'h2);
        chk("r_rdat", 32'(p_rdat), 32'hBEEF);
        p_stb = 2'b00;
        tick();
        chk("r_done", 32'({p_ack, busy}), 0);

        // 3: contention, both ports re-strobing immediately
        p_stb = 2'b11; p_we = 2'b11;
        for (int i = 0; i < 4; i++) begin
            serve(i % 2);
            p_stb[i % 2] = 1'b1;
        end
        p_stb = 2'b00;
        tick();

        // 4: controller not ready
        c_ready = 1'b0; p_stb = 2'b01; p_we = 2'b01;
        flag = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            flag |= c_wr_req | c_rd_req | busy | (|p_ack);
        end
        chk("nr_idle", 32'(flag), 0);
        c_ready = 1'b1;
        tick();
        chk("nr_start", 32'(c_wr_req), 1);
        c_wr_ack = 1'b1;
        tick();
        c_wr_ack = 1'b0;
        p_stb = 2'b00;
        tick();
        chk("nr_done", 32'({p_ack, busy}), 0);

        // 5: watchdog, controller never acks (pointer now 1, port 0 still wins)
        p_stb = 2'b01; p_we = 2'b01;
        tick();
        n = 0;
        while (c_wr_req && n < 30) begin
            n++;
            tick();
        end
        chk("wd_cycles", 32'(n), 8);
        chk("wd_err", 32'(tmo_err), 1);
        chk("wd_ack", 32'(p_ack), 32'h1);
        chk("wd_rdat_kept", 32'(p_rdat), 32'hBEEF);
        p_stb = 2'b00;
        tick();
        chk("wd_done", 32'({p_ack, busy, tmo_err}), 1);

        // 6: reset in the middle of a request
        p_stb = 2'b01; p_we = 2'b01; p_sel = 4'b0011;
        tick(); tick();
        chk("mr_req", 32'(c_wr_req), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mr_outs", 32'({c_wr_req, c_rd_req, p_ack, busy, tmo_err}), 0);
        chk("mr_dm", 32'(c_dm), 32'h3);
        serve(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
